rvco_freq_meter: RTL and testbench
==================================

// Module: rvco_freq_meter
// PURPOSE
//  Digital consumer of the ring-VCO output. One measurement runs through four phases:
//  - kick: pulses the VCO start-up gate low to pre-charge the supply node;
//  - settle: waits for the oscillator to stabilise;
//  - measure: counts VCO rising edges over a programmable window of CLK_REF cycles;
//  - report: presents the count on a valid/ready interface to the calibration and readout logic.
//  Fully synchronous to CLK_REF. osc_in is sampled through a synchronizer, never used as a clock.
// PARAMETERS
//  CNT_W      16  width of edge counter / count_out
//  WIN_W      16  width of win_len (measurement window, CLK_REF cycles)
//  KICK_CYC    8  cycles kick_n held low after start
//  SETTLE_CYC 64  cycles waited after kick before counting
// PORTS
//  CLK_REF        in   1      reference clock; all flops on rising edge
//  RESET_COUNTERn in   1      async active-low reset (assert async, deassert sync externally)
//  osc_in         in   1      ring-VCO output, asynchronous to CLK_REF
//  start          in   1      1-cycle request to start a measurement
//  win_len        in   WIN_W  window length; sampled on accepted start
//  kick_n         out  1      active-low drive to VCO start-up (vinit) gate
//  busy           out  1      high in any state other than IDLE
//  count_out      out  CNT_W  edges counted in the last window
//  overflow       out  1      count saturated during the last window
//  count_valid    out  1      count_out/overflow valid
//  count_ready    in   1      consumer accepts count
// BEHAVIOUR
//  Reset values: all outputs 0 except kick_n=1. FSM=IDLE. Sync chain and counters cleared.
//  Synchronizer: s1<=osc_in, s2<=s1, s3<=s2. Rising edge = s2 & ~s3.
//   Valid only for f_osc <= f_CLK_REF/4; faster inputs undercount (not detected).
//  FSM states: IDLE -> KICK -> SETTLE -> MEAS -> DONE -> IDLE.
//  IDLE:
//   - start=1: latch win_len into win_q; win_len=0 is latched as 1. Clear cnt and ovf. Go to KICK.
//   - start is ignored in every state except IDLE. No queuing.
//  KICK: kick_n=0 for exactly KICK_CYC cycles, then go to SETTLE.
//  SETTLE: kick_n=1. Wait SETTLE_CYC cycles, then go to MEAS.
//  MEAS:
//   - Lasts exactly win_q cycles. An edge detected in any MEAS cycle increments cnt.
//   - Edges seen outside MEAS are discarded, so sync-chain start-up glitches are never counted.
//   - cnt saturates at 2^CNT_W-1. If an edge arrives while saturated, set ovf=1.
//  DONE:
//   - On MEAS exit: count_out<=cnt, overflow<=ovf, count_valid<=1. First valid cycle is the
//     cycle after the last MEAS cycle.
//   - count_out and overflow are stable while count_valid=1 and ready=0.
//   - valid&ready: count_valid<=0 next cycle and go to IDLE. start is accepted no earlier
//     than the following cycle.
//  Latency: start accepted at cycle 0 -> count_valid first high at cycle
//   1+KICK_CYC+SETTLE_CYC+win_q (no back-pressure).
//  busy=1 from the cycle after start through the handshake cycle.
//  Counters: phase timer is max(WIN_W, clog2 of KICK/SETTLE) wide, counts down to 1, no wrap.
//  RESET_COUNTERn asserted mid-operation: immediate return to IDLE, kick_n=1, count_valid=0,
//   partial count discarded. Next start after release behaves like a fresh power-up.
//  start coincident with the reset release edge is ignored.
// TESTING
//  1. osc period 80ns, CLK_REF 10ns, win_len=800, ready=1 -> count_out 100+/-1,
//     overflow=0, valid at cycle 1+8+64+800=873.
//  2. osc held 0 (dead VCO), win_len=100 -> count_out=0, overflow=0; kick_n low for exactly 8 cycles.
//  3. CNT_W=4, osc period 40ns, win_len=200 -> count_out=15, overflow=1.
//  4. ready=0 for 20 cycles after valid; extra start pulses and osc activity ->
//     count_out/overflow stable, no new run; start 1 cycle after handshake is accepted.
//  5. Assert RESET_COUNTERn during MEAS at cycle 300 -> next cycle kick_n=1, busy=0,
//     count_valid=0; new run returns correct count.
//  6. win_len=0 -> MEAS lasts 1 cycle, valid at cycle 74; start during KICK/SETTLE ignored.

Source files
------------

// File: rtl/rvco_freq_meter.sv
// Ring-VCO frequency meter.
// Kicks the VCO start-up gate, waits for the oscillator to settle, then counts
// synchronised osc_in rising edges over a window of CLK_REF cycles. The result
// is held on a valid/ready interface until the consumer accepts it.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; win_len is captured when start is accepted
// S_KICK   | kick_n held low for KICK_CYC cycles to pre-charge the supply
// S_SETTLE | kick_n released, SETTLE_CYC cycles for the oscillator to settle
// S_MEAS   | win_q cycles of edge counting, saturating at all-ones
// S_DONE   | count_out/overflow held with count_valid until count_ready
`timescale 1ns/1ps
module rvco_freq_meter #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int KICK_CYC   = 8,
    parameter int SETTLE_CYC = 64
) (
    input  logic             CLK_REF,
    input  logic             RESET_COUNTERn,
    input  logic             osc_in,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             kick_n,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             overflow,
    output logic             count_valid,
    input  logic             count_ready
);

    // Phase timer must hold the window length as well as the fixed phase lengths.
    localparam int KICK_W = $clog2(KICK_CYC + 1);
    localparam int SETL_W = $clog2(SETTLE_CYC + 1);
    localparam int KS_W   = (KICK_W > SETL_W) ? KICK_W : SETL_W;
    localparam int TMR_W  = (WIN_W > KS_W) ? WIN_W : KS_W;

    localparam logic [TMR_W-1:0] T_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] T_KICK   = TMR_W'(KICK_CYC);
    localparam logic [TMR_W-1:0] T_SETTLE = TMR_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_SETTLE,
        S_MEAS,
        S_DONE
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [WIN_W-1:0]   win_q;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic               armed;
    logic               s1;
    logic               s2;
    logic               s3;
    logic               edge_det;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ovf_nxt;

    // Synchronise the asynchronous oscillator; s3 is the delayed copy for edge detect.
    always_ff @(posedge CLK_REF or negedge RESET_COUNTERn) begin
        if (!RESET_COUNTERn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;

    // Saturating increment of the edge count; an edge at saturation flags overflow.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (edge_det) begin
            if (cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_ONE;
            end
        end
    end

    // Measurement sequencer with registered outputs. 'armed' blocks a start that
    // lands on the first edge after reset release.
    always_ff @(posedge CLK_REF or negedge RESET_COUNTERn) begin
        if (!RESET_COUNTERn) begin
            state       <= S_IDLE;
            timer       <= '0;
            win_q       <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            armed       <= 1'b0;
            kick_n      <= 1'b1;
            busy        <= 1'b0;
            count_out   <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start && armed) begin
                        win_q  <= (win_len == '0) ? WIN_ONE : win_len;
                        cnt    <= '0;
                        ovf    <= 1'b0;
                        timer  <= T_KICK;
                        kick_n <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_KICK;
                    end
                end
                S_KICK: begin
                    if (timer == T_ONE) begin
                        kick_n <= 1'b1;
                        timer  <= T_SETTLE;
                        state  <= S_SETTLE;
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                S_SETTLE: begin
                    if (timer == T_ONE) begin
                        timer <= TMR_W'(win_q);
                        state <= S_MEAS;
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                S_MEAS: begin
                    cnt <= cnt_nxt;
                    ovf <= ovf_nxt;
                    if (timer == T_ONE) begin
                        // Include an edge seen in the final window cycle.
                        count_out   <= cnt_nxt;
                        overflow    <= ovf_nxt;
                        count_valid <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        timer <= timer - T_ONE;
                    end
                end
                S_DONE: begin
                    if (count_ready) begin
                        count_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    kick_n      <= 1'b1;
                    busy        <= 1'b0;
                    count_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvco_freq_meter.sv
// Directed bench for rvco_freq_meter: table of single measurements plus
// hand-written back-pressure, ignored-start and mid-run reset sequences.
// A second instance with a 4-bit counter shares all inputs to exercise saturation.
`timescale 1ns/1ps
module tb_rvco_freq_meter;

    localparam int BOUND = 2000;

    logic        CLK_REF;
    logic        RESET_COUNTERn;
    logic        osc_in;
    logic        start;
    logic [15:0] win_len;
    logic        count_ready;

    logic        kick_n,  busy,  overflow,  count_valid;
    logic [15:0] count_out;
    logic        kick_n4, busy4, overflow4, count_valid4;
    logic [3:0]  count_out4;

    int n_checks = 0;
    int n_fail   = 0;
    int osc_half = 0;

    rvco_freq_meter dut (
        .CLK_REF(CLK_REF), .RESET_COUNTERn(RESET_COUNTERn), .osc_in(osc_in),
        .start(start), .win_len(win_len), .kick_n(kick_n), .busy(busy),
        .count_out(count_out), .overflow(overflow), .count_valid(count_valid),
        .count_ready(count_ready)
    );

    rvco_freq_meter #(.CNT_W(4)) dut4 (
        .CLK_REF(CLK_REF), .RESET_COUNTERn(RESET_COUNTERn), .osc_in(osc_in),
        .start(start), .win_len(win_len), .kick_n(kick_n4), .busy(busy4),
        .count_out(count_out4), .overflow(overflow4), .count_valid(count_valid4),
        .count_ready(count_ready)
    );

    initial CLK_REF = 1'b0;
    always #5 CLK_REF = ~CLK_REF;

    // Oscillator model: half period in ns, 0 means a dead VCO held low.
    initial begin
        osc_in = 1'b0;
        forever begin
            if (osc_half == 0) begin
                osc_in = 1'b0;
                #1;
            end else begin
                #(osc_half) osc_in = ~osc_in;
            end
        end
    end

    typedef struct {
        int win;
        int half;
        int exp_cnt;
        int tol;
        int exp_ovf;
        int exp4_cnt;
        int exp4_ovf;
        int exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge of cycle 1.
    task automatic do_start(input int w);
        @(negedge CLK_REF);
        win_len = 16'(w);
        start   = 1'b1;
        @(negedge CLK_REF);
        start   = 1'b0;
    endtask

    // Walk cycles from cycle 1 until count_valid; lat = -1 on timeout.
    task automatic wait_result(output int lat, output int kicks);
        lat   = -1;
        kicks = 0;
        for (int cyc = 1; cyc <= BOUND; cyc++) begin
            if (!kick_n) kicks++;
            if (count_valid) begin
                lat = cyc;
                break;
            end
            @(negedge CLK_REF);
        end
    endtask

    initial begin
        int lat, kicks, cap_cnt, cap_ovf, ok;

        //          win  half  cnt tol ovf c4 o4 latency
        vecs[0] = '{800, 40,  100, 1,  0, 15, 1, 873};
        vecs[1] = '{100, 0,   0,   0,  0, 0,  0, 173};
        vecs[2] = '{200, 20,  50,  1,  0, 15, 1, 273};
        vecs[3] = '{0,   0,   0,   0,  0, 0,  0, 74};
        vecs[4] = '{40,  20,  10,  1,  0, 10, 0, 113};

        RESET_COUNTERn = 1'b0;
        start          = 1'b0;
        win_len        = '0;
        count_ready    = 1'b1;
        repeat (3) @(negedge CLK_REF);
        check("rst_kick_n", int'(kick_n), 1, 1);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_valid", int'(count_valid), 0, 0);
        check("rst_count", int'(count_out), 0, 0);
        check("rst_ovf", int'(overflow), 0, 0);
        RESET_COUNTERn = 1'b1;
        repeat (2) @(negedge CLK_REF);

        foreach (vecs[i]) begin
            osc_half = vecs[i].half;
            do_start(vecs[i].win);
            check($sformatf("v%0d_busy", i), int'(busy), 1, 1);
            wait_result(lat, kicks);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat, vecs[i].exp_lat);
            check($sformatf("v%0d_kick_cycles", i), kicks, 8, 8);
            check($sformatf("v%0d_count", i), int'(count_out),
                  vecs[i].exp_cnt - vecs[i].tol, vecs[i].exp_cnt + vecs[i].tol);
            check($sformatf("v%0d_ovf", i), int'(overflow), vecs[i].exp_ovf, vecs[i].exp_ovf);
            check($sformatf("v%0d_count4", i), int'(count_out4),
                  vecs[i].exp4_cnt - vecs[i].tol, vecs[i].exp4_cnt + vecs[i].tol);
            check($sformatf("v%0d_ovf4", i), int'(overflow4), vecs[i].exp4_ovf, vecs[i].exp4_ovf);
            @(negedge CLK_REF);
            check($sformatf("v%0d_valid_drop", i), int'(count_valid), 0, 0);
            check($sformatf("v%0d_idle", i), int'(busy), 0, 0);
            osc_half = 0;
            repeat (3) @(negedge CLK_REF);
        end

        // Back-pressure: result held, extra starts ignored, start after handshake accepted.
        count_ready = 1'b0;
        osc_half    = 20;
        do_start(40);
        wait_result(lat, kicks);
        check("bp_latency", lat, 113, 113);
        check("bp_count", int'(count_out), 9, 11);
        cap_cnt = int'(count_out);
        cap_ovf = int'(overflow);
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK_REF);
            start   = (i == 5 || i == 12);
            win_len = 16'd3;
            if (!count_valid || !busy || int'(count_out) != cap_cnt || int'(overflow) != cap_ovf)
                ok = 0;
        end
        start = 1'b0;
        check("bp_stable", ok, 1, 1);
        osc_half    = 0;
        count_ready = 1'b1;
        @(negedge CLK_REF);
        check("bp_valid_drop", int'(count_valid), 0, 0);
        check("bp_idle", int'(busy), 0, 0);
        win_len = 16'd0;
        start   = 1'b1;
        @(negedge CLK_REF);
        start   = 1'b0;
        check("bp_restart_busy", int'(busy), 1, 1);
        check("bp_restart_kick", int'(kick_n), 0, 0);
        wait_result(lat, kicks);
        check("bp_restart_latency", lat, 74, 74);
        check("bp_restart_count", int'(count_out), 0, 0);
        repeat (3) @(negedge CLK_REF);

        // Starts during KICK and SETTLE must not disturb the run or queue another.
        osc_half = 0;
        do_start(0);
        lat = -1;
        for (int cyc = 1; cyc <= BOUND; cyc++) begin
            start   = (cyc == 3 || cyc == 40);
            win_len = 16'd500;
            if (count_valid) begin
                lat = cyc;
                break;
            end
            @(negedge CLK_REF);
        end
        start = 1'b0;
        check("ign_latency", lat, 74, 74);
        ok = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK_REF);
            if (busy || count_valid) ok = 0;
        end
        check("ign_no_new_run", ok, 1, 1);

        // Reset in the middle of MEAS, start on the release edge, then a clean run.
        osc_half = 40;
        do_start(800);
        for (int cyc = 1; cyc < 300; cyc++) @(negedge CLK_REF);
        check("mid_in_meas", int'(busy), 1, 1);
        RESET_COUNTERn = 1'b0;
        @(negedge CLK_REF);
        check("mid_rst_kick_n", int'(kick_n), 1, 1);
        check("mid_rst_busy", int'(busy), 0, 0);
        check("mid_rst_valid", int'(count_valid), 0, 0);
        check("mid_rst_count", int'(count_out), 0, 0);
        RESET_COUNTERn = 1'b1;
        win_len = 16'd800;
        start   = 1'b1;
        @(negedge CLK_REF);
        start = 1'b0;
        check("rel_start_ignored", int'(busy), 0, 0);
        repeat (2) @(negedge CLK_REF);
        check("rel_still_idle", int'(busy), 0, 0);
        do_start(800);
        wait_result(lat, kicks);
        check("post_rst_latency", lat, 873, 873);
        check("post_rst_count", int'(count_out), 99, 101);
        check("post_rst_ovf", int'(overflow), 0, 0);
        check("post_rst_count4", int'(count_out4), 15, 15);
        check("post_rst_ovf4", int'(overflow4), 1, 1);
        osc_half = 0;
        repeat (3) @(negedge CLK_REF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
